// File: rtl/alu_iterative_exec_if.sv
// Request/result handshake bundle for the iterative execute ALU.
// master drives requests and result_ready; slave is the ALU side.
interface alu_iterative_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic                  ready_out;
  logic [3:0]            aluControl;
  logic [DATA_WIDTH-1:0] operandA;
  logic [DATA_WIDTH-1:0] operandB;
  logic                  result_valid;
  logic                  result_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  overflow;

  modport master (
    output valid_in,
    output aluControl,
    output operandA,
    output operandB,
    output result_ready,
    input  ready_out,
    input  result_valid,
    input  result,
    input  zero,
    input  overflow
  );

  modport slave (
    input  valid_in,
    input  aluControl,
    input  operandA,
    input  operandB,
    input  result_ready,
    output ready_out,
    output result_valid,
    output result,
    output zero,
    output overflow
  );
endinterface

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU: single-cycle logic/arith, bit-serial shifter.
// Ports: clock, reset (sync high), flush, bus (slave handshake).
module alu_iterative_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  alu_iterative_exec_if.slave bus
);

  localparam logic [3:0] ALU_ZERO = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shkind_t;

  state_t                 state;
  state_t                 state_nx;
  shkind_t                kind;
  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  acc_step;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   ovf;

  logic [DATA_WIDTH-1:0]  a;
  logic [DATA_WIDTH-1:0]  b;
  logic [DATA_WIDTH-1:0]  sum;
  logic [DATA_WIDTH-1:0]  diff;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_ovf;
  logic [SHAMT_WIDTH-1:0] shamt;

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_slt;
  logic is_sll;
  logic is_srl;
  logic is_sra;
  logic is_lui;
  logic is_shift;
  logic accept;
  logic done;

  assign a     = bus.operandA;
  assign b     = bus.operandB;
  assign shamt = a[SHAMT_WIDTH-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  assign is_add   = bus.aluControl == ALU_ADD;
  assign is_sub   = bus.aluControl == ALU_SUB;
  assign is_and   = bus.aluControl == ALU_AND;
  assign is_or    = bus.aluControl == ALU_OR;
  assign is_xor   = bus.aluControl == ALU_XOR;
  assign is_slt   = bus.aluControl == ALU_SLT;
  assign is_sll   = bus.aluControl == ALU_SLL;
  assign is_srl   = bus.aluControl == ALU_SRL;
  assign is_sra   = bus.aluControl == ALU_SRA;
  assign is_lui   = bus.aluControl == ALU_LUI;
  assign is_shift = is_sll | is_srl | is_sra;

  assign bus.ready_out = (state == IDLE) && !reset;
  assign accept = bus.valid_in && bus.ready_out && !flush;

  // ALU_ZERO and undefined codes fall to the default: result 0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (1'b1)
      is_add: begin
        alu_res = sum;
        alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      is_sub: begin
        alu_res = diff;
        alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      is_and: alu_res = a & b;
      is_or:  alu_res = a | b;
      is_xor: alu_res = a ^ b;
      is_slt: alu_res = {{MSB{1'b0}}, $signed(a) < $signed(b)};
      is_lui: alu_res = {b[15:0], 16'h0};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    acc_step = acc;
    unique case (kind)
      SH_LL:   acc_step = {acc[MSB-1:0], 1'b0};
      SH_RL:   acc_step = {1'b0, acc[MSB:1]};
      default: acc_step = {acc[MSB], acc[MSB:1]};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state_nx = SHIFT;
            end else begin
              state_nx = DONE;
            end
          end
        end
        SHIFT: begin
          if (cnt == SHAMT_WIDTH'(1)) begin
            state_nx = DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // acc doubles as the shift register and the held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      kind <= SH_LL;
    end else if (flush) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc <= is_shift ? b : alu_res;
            ovf <= alu_ovf;
            cnt <= is_shift ? shamt : '0;
            if (is_sll) begin
              kind <= SH_LL;
            end else if (is_srl) begin
              kind <= SH_RL;
            end else begin
              kind <= SH_RA;
            end
          end
        end
        SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - SHAMT_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign done             = state == DONE;
  assign bus.result_valid = done;
  assign bus.result       = done ? acc : '0;
  assign bus.zero         = done && (acc == '0);
  assign bus.overflow     = done && ovf;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec.
// Each task drives one scenario and checks inline.
module tb_alu_iterative_exec;

  localparam logic [3:0] ALU_ZERO = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  logic clock;
  logic reset;
  logic flush;
  int   checks;
  int   failures;

  alu_iterative_exec_if #(.DATA_WIDTH(32)) bus ();

  alu_iterative_exec #(
    .DATA_WIDTH(32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.valid_in   = 1'b1;
    bus.aluControl = c;
    bus.operandA   = a;
    bus.operandB   = b;
    tick();
    bus.valid_in   = 1'b0;
    bus.operandA   = 32'hDEAD_BEEF;
    bus.operandB   = 32'h1357_9BDF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ready_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=0", bus.ready_out);
    end
    checks++;
    if ({bus.result_valid, bus.result, bus.zero, bus.overflow} !== 35'd0) begin
      failures++;
      $display("FAIL rst_outs got=%b/%h/%b/%b exp=0", bus.result_valid,
               bus.result, bus.zero, bus.overflow);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_ready got=%b exp=1", bus.ready_out);
    end
  endtask

  task automatic test_add();
    bus.result_ready = 1'b1;
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++;
    if ({bus.result_valid, bus.result, bus.overflow, bus.zero}
        !== {1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_ovf got=%b/%h/%b/%b exp=1/80000000/1/0",
               bus.result_valid, bus.result, bus.overflow, bus.zero);
    end
    checks++;
    if (bus.ready_out !== 1'b0) begin
      failures++;
      $display("FAIL add_busy got=%b exp=0", bus.ready_out);
    end
    tick();
    checks++;
    if ({bus.ready_out, bus.result_valid} !== 2'b10) begin
      failures++;
      $display("FAIL add_idle got=%b%b exp=10", bus.ready_out,
               bus.result_valid);
    end
  endtask

  task automatic test_sub_slt();
    bus.result_ready = 1'b1;
    issue(ALU_SUB, 32'd5, 32'd5);
    checks++;
    if ({bus.result_valid, bus.result, bus.zero, bus.overflow}
        !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_zero got=%b/%h/%b/%b exp=1/00000000/1/0",
               bus.result_valid, bus.result, bus.zero, bus.overflow);
    end
    tick();
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++;
    if ({bus.result_valid, bus.result, bus.zero, bus.overflow}
        !== {1'b1, 32'h1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL slt_signed got=%b/%h/%b/%b exp=1/00000001/0/0",
               bus.result_valid, bus.result, bus.zero, bus.overflow);
    end
    tick();
    issue(ALU_SUB, 32'h8000_0000, 32'h0000_0001);
    checks++;
    if ({bus.result, bus.overflow} !== {32'h7FFF_FFFF, 1'b1}) begin
      failures++;
      $display("FAIL sub_ovf got=%h/%b exp=7fffffff/1", bus.result,
               bus.overflow);
    end
    tick();
  endtask

  task automatic test_logic();
    bus.result_ready = 1'b1;
    issue(ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F);
    checks++;
    if (bus.result !== 32'hF0F0_0F0F) begin
      failures++;
      $display("FAIL or got=%h exp=f0f00f0f", bus.result);
    end
    tick();
    issue(ALU_XOR, 32'hFFFF_0000, 32'hFF00_FF00);
    checks++;
    if (bus.result !== 32'h00FF_FF00) begin
      failures++;
      $display("FAIL xor got=%h exp=00ffff00", bus.result);
    end
    tick();
    issue(4'hF, 32'h1234_5678, 32'h1111_1111);
    checks++;
    if ({bus.result_valid, bus.result, bus.zero}
        !== {1'b1, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL undef_code got=%b/%h/%b exp=1/00000000/1",
               bus.result_valid, bus.result, bus.zero);
    end
    tick();
    issue(ALU_ZERO, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    checks++;
    if ({bus.result, bus.zero, bus.overflow} !== {32'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL alu_zero got=%h/%b/%b exp=00000000/1/0",
               bus.result, bus.zero, bus.overflow);
    end
    tick();
  endtask

  task automatic test_shift();
    bit bad;
    bus.result_ready = 1'b1;
    issue(ALU_SRA, 32'd4, 32'h8000_0000);
    bad = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (bus.result_valid !== 1'b0 || bus.ready_out !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL sra_busy got=early_valid_or_ready exp=busy");
    end
    checks++;
    if ({bus.result_valid, bus.ready_out, bus.result, bus.overflow}
        !== {1'b1, 1'b0, 32'hF800_0000, 1'b0}) begin
      failures++;
      $display("FAIL sra_result got=%b/%b/%h/%b exp=1/0/f8000000/0",
               bus.result_valid, bus.ready_out, bus.result, bus.overflow);
    end
    tick();
    issue(ALU_SRL, 32'd4, 32'h8000_0000);
    tick();
    tick();
    tick();
    tick();
    checks++;
    if ({bus.result_valid, bus.result} !== {1'b1, 32'h0800_0000}) begin
      failures++;
      $display("FAIL srl_result got=%b/%h exp=1/08000000",
               bus.result_valid, bus.result);
    end
    tick();
    issue(ALU_SLL, 32'd0, 32'h8000_0000);
    checks++;
    if ({bus.result_valid, bus.result} !== {1'b1, 32'h8000_0000}) begin
      failures++;
      $display("FAIL sll_n0 got=%b/%h exp=1/80000000",
               bus.result_valid, bus.result);
    end
    tick();
    issue(ALU_SLL, 32'hFFFF_FFE1, 32'h0000_0003);
    checks++;
    if ({bus.result_valid, bus.result} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL sll_n1_early got=%b/%h exp=0/00000000",
               bus.result_valid, bus.result);
    end
    tick();
    checks++;
    if ({bus.result_valid, bus.result} !== {1'b1, 32'h0000_0006}) begin
      failures++;
      $display("FAIL sll_n1 got=%b/%h exp=1/00000006",
               bus.result_valid, bus.result);
    end
    tick();
  endtask

  task automatic test_hold();
    bit bad;
    bus.result_ready = 1'b0;
    issue(ALU_LUI, 32'hFFFF_FFFF, 32'h0000_1234);
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if ({bus.result_valid, bus.ready_out, bus.result, bus.zero}
          !== {1'b1, 1'b0, 32'h1234_0000, 1'b0}) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL lui_hold got=unstable exp=12340000_held");
    end
    bus.result_ready = 1'b1;
    checks++;
    if ({bus.result_valid, bus.result} !== {1'b1, 32'h1234_0000}) begin
      failures++;
      $display("FAIL lui_4th got=%b/%h exp=1/12340000",
               bus.result_valid, bus.result);
    end
    tick();
    checks++;
    if ({bus.result_valid, bus.ready_out} !== 2'b01) begin
      failures++;
      $display("FAIL lui_release got=%b%b exp=01", bus.result_valid,
               bus.ready_out);
    end
  endtask

  task automatic test_back_to_back();
    bus.result_ready = 1'b1;
    bus.valid_in   = 1'b1;
    bus.aluControl = ALU_ADD;
    bus.operandA   = 32'd10;
    bus.operandB   = 32'd20;
    tick();
    checks++;
    if ({bus.result_valid, bus.ready_out, bus.result}
        !== {1'b1, 1'b0, 32'd30}) begin
      failures++;
      $display("FAIL b2b_first got=%b/%b/%h exp=1/0/0000001e",
               bus.result_valid, bus.ready_out, bus.result);
    end
    bus.operandA = 32'd7;
    bus.operandB = 32'd8;
    tick();
    checks++;
    if ({bus.result_valid, bus.ready_out} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_gap got=%b%b exp=01", bus.result_valid,
               bus.ready_out);
    end
    tick();
    bus.valid_in = 1'b0;
    checks++;
    if ({bus.result_valid, bus.result} !== {1'b1, 32'd15}) begin
      failures++;
      $display("FAIL b2b_second got=%b/%h exp=1/0000000f",
               bus.result_valid, bus.result);
    end
    tick();
  endtask

  task automatic test_flush();
    bit bad;
    bus.result_ready = 1'b1;
    issue(ALU_SLL, 32'd31, 32'h0000_0001);
    bad = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (bus.result_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    flush          = 1'b1;
    bus.valid_in   = 1'b1;
    bus.aluControl = ALU_ADD;
    bus.operandA   = 32'd1;
    bus.operandB   = 32'd1;
    tick();
    flush        = 1'b0;
    bus.valid_in = 1'b0;
    checks++;
    if ({bus.ready_out, bus.result_valid} !== 2'b10) begin
      failures++;
      $display("FAIL flush_idle got=%b%b exp=10", bus.ready_out,
               bus.result_valid);
    end
    for (int k = 0; k < 40; k++) begin
      if (bus.result_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_no_result got=result_valid exp=none");
    end
  endtask

  task automatic test_reset_mid();
    bus.result_ready = 1'b1;
    issue(ALU_SRA, 32'd10, 32'h8000_0000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.result_valid, bus.ready_out, bus.result, bus.zero, bus.overflow}
        !== 36'd0) begin
      failures++;
      $display("FAIL rst_mid_shift got=%b/%b/%h/%b/%b exp=0",
               bus.result_valid, bus.ready_out, bus.result, bus.zero,
               bus.overflow);
    end
    reset = 1'b0;
    tick();
    bus.result_ready = 1'b0;
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.result_valid, bus.ready_out, bus.result, bus.zero, bus.overflow}
        !== 36'd0) begin
      failures++;
      $display("FAIL rst_mid_done got=%b/%b/%h/%b/%b exp=0",
               bus.result_valid, bus.ready_out, bus.result, bus.zero,
               bus.overflow);
    end
    reset = 1'b0;
    bus.result_ready = 1'b1;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_ready got=%b exp=1", bus.ready_out);
    end
    issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checks++;
    if ({bus.result_valid, bus.result, bus.overflow}
        !== {1'b1, 32'hF000_F000, 1'b0}) begin
      failures++;
      $display("FAIL and_after_rst got=%b/%h/%b exp=1/f000f000/0",
               bus.result_valid, bus.result, bus.overflow);
    end
    tick();
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    flush            = 1'b0;
    bus.valid_in     = 1'b0;
    bus.aluControl   = 4'd0;
    bus.operandA     = 32'd0;
    bus.operandB     = 32'd0;
    bus.result_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_shift();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iterative_exec.md
Name: alu_iterative_exec

Overview:
- Execute-stage datapath that consumes the 4-bit ALU control code produced by the arithmetical control decoder and computes the result.
- Logic ops, add/sub, SLT and LUI complete in one cycle.
- SLL/SRL/SRA use an area-saving iterative shifter, one bit per cycle.
- A valid/ready handshake on each side lets the pipeline stall while a shift is in flight; a flush input aborts in-flight work on branch or exception.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from operandA; must equal log2(DATA_WIDTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous abort of any in-flight or held operation.
- valid_in  in  1  operation request.
- ready_out  out  1  unit can accept a request this cycle.
- aluControl  in  4  ALU code from MIPSConstants: ALU_ZERO, ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA, LUI.
- operandA  in  DATA_WIDTH  rs value; bits [SHAMT_WIDTH-1:0] are the shift amount for shifts.
- operandB  in  DATA_WIDTH  rt value or immediate; this is the value being shifted.
- result_valid  out  1  result is present.
- result_ready  in  1  downstream accepts the result.
- result  out  DATA_WIDTH  computed value.
- zero  out  1  result == 0; qualified by result_valid.
- overflow  out  1  signed overflow on ADD/SUB only.

Behaviour:
- States: IDLE, SHIFT, DONE. Operands and code are registered on accept.
- ready_out = (state==IDLE) && !reset. Accept happens in cycle T when valid_in && ready_out && !flush.
- Non-shift codes: go to DONE; result_valid=1 at T+1.
- Shift with amount n>0: go to SHIFT with counter=n. Each cycle shift by 1 and decrement; when counter reaches 1, the next state is DONE. result_valid=1 at T+1+n.
- Shift with n=0: direct to DONE; result = operandB at T+1.
- DONE: result, zero and overflow are held stable while result_valid && !result_ready. On result_ready, go to IDLE next cycle. No accept occurs in DONE, so throughput is at most 1 op per 2 cycles.
- Arithmetic:
  - ADD/SUB are modulo 2^DATA_WIDTH.
  - overflow = operand signs agree (B inverted for SUB) and result sign differs. overflow=0 for every other code.
  - SLT is a signed compare; result is 1 or 0.
  - SRA replicates the MSB.
  - LUI = {operandB[15:0], 16'b0}.
  - ALU_ZERO or any undefined code gives result 0 in one cycle, with zero=1.
- flush: highest priority after reset. Next state is IDLE, result_valid=0 next cycle, and no result is ever produced for the aborted op. A valid_in in the same cycle is not accepted.
- reset: state IDLE. result_valid, result, zero, overflow and the counter are all 0. ready_out=0 while reset is high and 1 the cycle after. Reset mid-shift discards the shift.
- Inputs are sampled only on the accept cycle; later changes to them do not affect the op in flight.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, result_ready=1 -> result 0x80000000, overflow=1, zero=0 at T+1; ready_out high at T+2.
- SUB 5-5, then SLT A=0xFFFFFFFF, B=0x00000001 -> first result 0 with zero=1; second result 1, overflow=0.
- SRA operandB=0x80000000, operandA=4 -> ready_out low for T+1..T+5, result_valid at T+5 with 0xF8000000. Repeat with SRL -> 0x08000000. SLL with A=0 -> 0x80000000 at T+1.
- LUI operandB=0x00001234, result_ready held low 3 cycles -> result 0x12340000 stable and result_valid held; accepted on the 4th cycle, then IDLE.
- SLL amount 31, flush at T+10 with valid_in=1 -> no result_valid ever for the shift, the flushed-cycle request is not accepted, ready_out=1 at T+11.
- reset asserted mid-shift and mid-DONE -> all outputs 0 the next cycle. The first post-reset request, AND 0xF0F0F0F0 & 0xFF00FF00, gives 0xF000F000.
